// File: rtl/fifo_traffic_gen_pkg.sv
// Shared definitions for the FIFO traffic generator: pattern mode codes,
// run-state encoding and a small helper for burst period arithmetic.
package fifo_traffic_gen_pkg;

  localparam int MODE_INC  = 0;
  localparam int MODE_LFSR = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Length of one on/off burst period in cycles.
  function automatic int phase_period(input int on_cycles, input int off_cycles);
    return on_cycles + off_cycles;
  endfunction

endpackage

// File: rtl/fifo_pattern_gen.sv
// Data pattern source: incrementing counter or Galois LFSR.
// Reloaded with the seed on load, steps once per advance.
module fifo_pattern_gen
  import fifo_traffic_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    MODE       = MODE_INC,
  parameter int                    SEED       = 1,
  parameter logic [DATA_WIDTH-1:0] POLY       = DATA_WIDTH'(8'hB8)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] value
);

  // An all-zero LFSR state would lock up, so a zero seed starts at 1 instead.
  localparam logic [DATA_WIDTH-1:0] INIT_VAL =
    ((MODE == MODE_LFSR) && (SEED == 0)) ? DATA_WIDTH'(1) : DATA_WIDTH'(SEED);

  logic [DATA_WIDTH-1:0] value_r;
  logic [DATA_WIDTH-1:0] next_s;

  // Next pattern value for the selected mode.
  always_comb begin
    next_s = value_r;
    if (MODE == MODE_LFSR) begin
      next_s = (value_r >> 1) ^ (value_r[0] ? POLY : {DATA_WIDTH{1'b0}});
    end else begin
      next_s = value_r + DATA_WIDTH'(1);
    end
  end

  // Pattern register: seed on reset/load, step on advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_r <= INIT_VAL;
    end else if (load) begin
      value_r <= INIT_VAL;
    end else if (advance) begin
      value_r <= next_s;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/fifo_traffic_gen.sv
// FIFO stimulus and self-check engine. Writes NUM_WORDS patterned words in
// on/off bursts honouring full, reads them back in independent bursts
// honouring empty, and compares each returned word with the expected stream.
module fifo_traffic_gen
  import fifo_traffic_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_WORDS  = 64,
  parameter int                    WR_ON      = 4,
  parameter int                    WR_OFF     = 2,
  parameter int                    RD_ON      = 3,
  parameter int                    RD_OFF     = 3,
  parameter int                    MODE       = MODE_INC,
  parameter int                    SEED       = 1,
  parameter logic [DATA_WIDTH-1:0] POLY       = DATA_WIDTH'(8'hB8),
  parameter int                    RD_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  full,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           error_count
);

  localparam int CNT_W   = $clog2(NUM_WORDS + 1);
  localparam int WR_PER  = phase_period(WR_ON, WR_OFF);
  localparam int RD_PER  = phase_period(RD_ON, RD_OFF);
  localparam int WR_PH_W = $clog2(WR_PER + 1);
  localparam int RD_PH_W = $clog2(RD_PER + 1);

  localparam logic [CNT_W-1:0]   NUM_WORDS_C = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0]   LAST_WORD   = CNT_W'(NUM_WORDS - 1);
  localparam logic [WR_PH_W-1:0] WR_ON_C     = WR_PH_W'(WR_ON);
  localparam logic [WR_PH_W-1:0] WR_LAST_PH  = WR_PH_W'(WR_PER - 1);
  localparam logic [RD_PH_W-1:0] RD_ON_C     = RD_PH_W'(RD_ON);
  localparam logic [RD_PH_W-1:0] RD_LAST_PH  = RD_PH_W'(RD_PER - 1);

  state_t                  state_r;
  logic [CNT_W-1:0]        wr_cnt_r;
  logic [CNT_W-1:0]        rd_cnt_r;
  logic [CNT_W-1:0]        chk_cnt_r;
  logic [WR_PH_W-1:0]      wr_ph_r;
  logic [RD_PH_W-1:0]      rd_ph_r;
  logic [RD_LATENCY-1:0]   rd_dly_r;
  logic                    error_r;
  logic [15:0]             err_cnt_r;

  logic                    launch_s;
  logic                    run_s;
  logic                    active_s;
  logic                    wr_en_s;
  logic                    rd_en_s;
  logic                    chk_s;
  logic [DATA_WIDTH-1:0]   wr_val_s;
  logic [DATA_WIDTH-1:0]   exp_val_s;

  assign run_s    = (state_r == ST_RUN);
  assign active_s = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign launch_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  // Strobes are combinational from full/empty so the FIFO flags act the same cycle.
  assign wr_en_s = run_s && (wr_ph_r < WR_ON_C) && !full;
  assign rd_en_s = active_s && (rd_ph_r < RD_ON_C) && !empty && (rd_cnt_r < NUM_WORDS_C);
  assign chk_s   = active_s && rd_dly_r[RD_LATENCY-1];

  fifo_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODE       (MODE),
    .SEED       (SEED),
    .POLY       (POLY)
  ) u_wr_gen (
    .clock   (clock),
    .reset   (reset),
    .load    (launch_s),
    .advance (wr_en_s),
    .value   (wr_val_s)
  );

  fifo_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .MODE       (MODE),
    .SEED       (SEED),
    .POLY       (POLY)
  ) u_chk_gen (
    .clock   (clock),
    .reset   (reset),
    .load    (launch_s),
    .advance (chk_s),
    .value   (exp_val_s)
  );

  // Run sequencing: RUN until all writes land, DRAIN until all reads are checked.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (wr_en_s && (wr_cnt_r == LAST_WORD)) state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (chk_s && (chk_cnt_r == LAST_WORD)) state_r <= ST_DONE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Words written, reads issued and reads checked in the current run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt_r  <= {CNT_W{1'b0}};
      rd_cnt_r  <= {CNT_W{1'b0}};
      chk_cnt_r <= {CNT_W{1'b0}};
    end else if (launch_s) begin
      wr_cnt_r  <= {CNT_W{1'b0}};
      rd_cnt_r  <= {CNT_W{1'b0}};
      chk_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) wr_cnt_r  <= wr_cnt_r + CNT_W'(1);
      if (rd_en_s) rd_cnt_r  <= rd_cnt_r + CNT_W'(1);
      if (chk_s)   chk_cnt_r <= chk_cnt_r + CNT_W'(1);
    end
  end

  // Burst phase counters: restart in the on phase at launch, free-run while active.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ph_r <= {WR_PH_W{1'b0}};
      rd_ph_r <= {RD_PH_W{1'b0}};
    end else if (launch_s || !active_s) begin
      wr_ph_r <= {WR_PH_W{1'b0}};
      rd_ph_r <= {RD_PH_W{1'b0}};
    end else begin
      wr_ph_r <= (wr_ph_r == WR_LAST_PH) ? {WR_PH_W{1'b0}} : wr_ph_r + WR_PH_W'(1);
      rd_ph_r <= (rd_ph_r == RD_LAST_PH) ? {RD_PH_W{1'b0}} : rd_ph_r + RD_PH_W'(1);
    end
  end

  // Read strobe delayed to line up with the FIFO's read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_dly_r <= {RD_LATENCY{1'b0}};
    end else if (launch_s) begin
      rd_dly_r <= {RD_LATENCY{1'b0}};
    end else begin
      rd_dly_r[0] <= rd_en_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_dly_r[i] <= rd_dly_r[i-1];
      end
    end
  end

  // Sticky mismatch flag and saturating mismatch count, cleared at launch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_r   <= 1'b0;
      err_cnt_r <= 16'h0000;
    end else if (launch_s) begin
      error_r   <= 1'b0;
      err_cnt_r <= 16'h0000;
    end else if (chk_s && (rd_data != exp_val_s)) begin
      error_r <= 1'b1;
      if (err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
    end
  end

  assign data         = wr_val_s;
  assign write_enable = wr_en_s;
  assign read_enable  = rd_en_s;
  assign busy         = active_s;
  assign done         = (state_r == ST_DONE);
  assign error        = error_r;
  assign error_count  = err_cnt_r;

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Directed bench: three generator instances (default, LFSR, long-latency
// continuous) each beside a small behavioural FIFO model.
module tb_fifo_traffic_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A: default parameters ----------------
  logic        rst_a, start_a, full_a, empty_a, force_full_a;
  logic [7:0]  rd_a, data_a;
  logic        we_a, re_a, busy_a, done_a, err_a;
  logic [15:0] ecnt_a;
  logic [7:0]  q_a[$];
  logic [7:0]  wlog_a[$];
  int          cnt_a, pops_a, viol_a, corrupt_at_a;

  assign full_a  = force_full_a;
  assign empty_a = (cnt_a == 0);

  fifo_traffic_gen u_dut_a (
    .clock(clock), .reset(rst_a), .start(start_a), .full(full_a), .empty(empty_a),
    .rd_data(rd_a), .data(data_a), .write_enable(we_a), .read_enable(re_a),
    .busy(busy_a), .done(done_a), .error(err_a), .error_count(ecnt_a)
  );

  // FIFO model A: latency-1 read, optional single-word corruption.
  always @(posedge clock or posedge rst_a) begin
    if (rst_a) begin
      q_a.delete();
      cnt_a <= 0;
      rd_a  <= 8'h00;
    end else begin
      if (we_a && full_a) viol_a <= viol_a + 1;
      if (re_a) begin
        rd_a   <= q_a.pop_front() ^ ((pops_a == corrupt_at_a) ? 8'h01 : 8'h00);
        pops_a <= pops_a + 1;
      end
      if (we_a) begin
        q_a.push_back(data_a);
        wlog_a.push_back(data_a);
      end
      cnt_a <= cnt_a + (we_a ? 1 : 0) - (re_a ? 1 : 0);
    end
  end

  // ---------------- DUT B: LFSR, zero seed ----------------
  logic        rst_bc, start_b, empty_b;
  logic        full_b = 1'b0;
  logic [7:0]  rd_b, data_b;
  logic        we_b, re_b, busy_b, done_b, err_b;
  logic [15:0] ecnt_b;
  logic [7:0]  q_b[$];
  logic [7:0]  wlog_b[$];
  int          cnt_b;

  assign empty_b = (cnt_b == 0);

  fifo_traffic_gen #(.MODE(1), .SEED(0), .POLY(8'hB8)) u_dut_b (
    .clock(clock), .reset(rst_bc), .start(start_b), .full(full_b), .empty(empty_b),
    .rd_data(rd_b), .data(data_b), .write_enable(we_b), .read_enable(re_b),
    .busy(busy_b), .done(done_b), .error(err_b), .error_count(ecnt_b)
  );

  // FIFO model B: latency-1 read.
  always @(posedge clock or posedge rst_bc) begin
    if (rst_bc) begin
      q_b.delete();
      cnt_b <= 0;
      rd_b  <= 8'h00;
    end else begin
      if (re_b) rd_b <= q_b.pop_front();
      if (we_b) begin
        q_b.push_back(data_b);
        wlog_b.push_back(data_b);
      end
      cnt_b <= cnt_b + (we_b ? 1 : 0) - (re_b ? 1 : 0);
    end
  end

  // ---------------- DUT C: latency 3, continuous bursts ----------------
  logic        start_c, empty_c;
  logic        full_c = 1'b0;
  logic [7:0]  rd_c, data_c;
  logic        we_c, re_c, busy_c, done_c, err_c;
  logic [15:0] ecnt_c;
  logic [7:0]  q_c[$];
  logic [7:0]  wlog_c[$];
  logic [7:0]  pipe_c [0:2];
  int          cnt_c, pops_c;

  assign empty_c = (cnt_c == 0);
  assign rd_c    = pipe_c[2];

  fifo_traffic_gen #(.WR_OFF(0), .RD_OFF(0), .RD_LATENCY(3)) u_dut_c (
    .clock(clock), .reset(rst_bc), .start(start_c), .full(full_c), .empty(empty_c),
    .rd_data(rd_c), .data(data_c), .write_enable(we_c), .read_enable(re_c),
    .busy(busy_c), .done(done_c), .error(err_c), .error_count(ecnt_c)
  );

  // FIFO model C: three-stage read data pipeline.
  always @(posedge clock or posedge rst_bc) begin
    if (rst_bc) begin
      q_c.delete();
      cnt_c <= 0;
      pipe_c[0] <= 8'h00; pipe_c[1] <= 8'h00; pipe_c[2] <= 8'h00;
    end else begin
      if (re_c) begin
        pipe_c[0] <= q_c.pop_front();
        pops_c    <= pops_c + 1;
      end else begin
        pipe_c[0] <= 8'h00;
      end
      pipe_c[1] <= pipe_c[0];
      pipe_c[2] <= pipe_c[1];
      if (we_c) begin
        q_c.push_back(data_c);
        wlog_c.push_back(data_c);
      end
      cnt_c <= cnt_c + (we_c ? 1 : 0) - (re_c ? 1 : 0);
    end
  end

  // Compares 64 logged writes of DUT A from base against 01,02,...,40h.
  task automatic check_log_a(input string tag, input int base);
    int errs = 0;
    check_eq({tag, " count"}, wlog_a.size() - base, 64);
    for (int i = 0; i < 64 && (base + i) < wlog_a.size(); i++) begin
      if (wlog_a[base + i] !== 8'(i + 1)) errs++;
    end
    check_eq({tag, " words"}, errs, 0);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 3000 && done_a !== 1'b1; i++) @(negedge clock);
  endtask

  int          base, pbase, v, d, gaps;
  logic [7:0]  held, lf;
  logic [11:0] pat;

  initial begin
    rst_a = 1'b1; rst_bc = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    force_full_a = 1'b0; corrupt_at_a = -1;
    repeat (2) @(negedge clock);

    // Reset state
    check_eq("rst we", we_a, 1'b0);
    check_eq("rst re", re_a, 1'b0);
    check_eq("rst busy", busy_a, 1'b0);
    check_eq("rst done", done_a, 1'b0);
    check_eq("rst error", err_a, 1'b0);
    check_eq("rst ecnt", ecnt_a, 16'h0000);
    check_eq("rst data", data_a, 8'h01);
    check_eq("rst data lfsr", data_b, 8'h01);
    rst_a = 1'b0; rst_bc = 1'b0;
    @(negedge clock);

    // 1: default run, 4-on/2-off write bursts, clean check
    base = wlog_a.size(); pbase = pops_a;
    pulse_start_a();
    pat = 12'h000;
    for (int i = 0; i < 12; i++) begin
      pat = {pat[10:0], we_a};
      @(negedge clock);
    end
    check_eq("t1 wr burst", pat, 12'b1111_0011_1100);
    wait_done_a();
    check_eq("t1 done", done_a, 1'b1);
    check_eq("t1 busy at done", busy_a, 1'b0);
    check_eq("t1 error", err_a, 1'b0);
    check_eq("t1 ecnt", ecnt_a, 16'h0000);
    check_eq("t1 reads", pops_a - pbase, 64);
    check_log_a("t1 log", base);

    // 2: full held for 10 cycles mid-burst
    base = wlog_a.size();
    pulse_start_a();
    for (int i = 0; i < 500 && !((wlog_a.size() - base) >= 10 && we_a); i++) @(negedge clock);
    check_eq("t2 mid burst", we_a, 1'b1);
    held = data_a; v = 0; d = 0;
    force_full_a = 1'b1;
    repeat (10) begin
      #1;
      if (we_a !== 1'b0) v++;
      if (data_a !== held) d++;
      @(negedge clock);
    end
    force_full_a = 1'b0;
    check_eq("t2 we while full", v, 0);
    check_eq("t2 data held", d, 0);
    wait_done_a();
    check_eq("t2 done", done_a, 1'b1);
    check_eq("t2 error", err_a, 1'b0);
    check_eq("t2 full violations", viol_a, 0);
    check_log_a("t2 log", base);

    // 4: one corrupted word, then a restart clears the error
    base = wlog_a.size();
    corrupt_at_a = pops_a + 5;
    pulse_start_a();
    wait_done_a();
    check_eq("t4 done", done_a, 1'b1);
    check_eq("t4 error", err_a, 1'b1);
    check_eq("t4 ecnt", ecnt_a, 16'h0001);
    check_log_a("t4 log", base);
    pulse_start_a();
    check_eq("t4 restart busy", busy_a, 1'b1);
    check_eq("t4 restart error", err_a, 1'b0);
    check_eq("t4 restart ecnt", ecnt_a, 16'h0000);
    wait_done_a();
    check_eq("t4 rerun ecnt", ecnt_a, 16'h0000);

    // 6: reset during DRAIN, then a clean run
    base = wlog_a.size();
    pulse_start_a();
    for (int i = 0; i < 1000 && !((wlog_a.size() - base) == 64 && busy_a); i++) @(negedge clock);
    check_eq("t6 in drain", busy_a && ((wlog_a.size() - base) == 64) && !done_a, 1'b1);
    rst_a = 1'b1;
    #1;
    check_eq("t6 rst we", we_a, 1'b0);
    check_eq("t6 rst re", re_a, 1'b0);
    check_eq("t6 rst busy", busy_a, 1'b0);
    check_eq("t6 rst done", done_a, 1'b0);
    check_eq("t6 rst error", err_a, 1'b0);
    check_eq("t6 rst ecnt", ecnt_a, 16'h0000);
    check_eq("t6 rst data", data_a, 8'h01);
    @(negedge clock);
    rst_a = 1'b0;
    @(negedge clock);
    base = wlog_a.size();
    pulse_start_a();
    wait_done_a();
    check_eq("t6 done", done_a, 1'b1);
    check_eq("t6 error", err_a, 1'b0);
    check_eq("t6 ecnt", ecnt_a, 16'h0000);
    check_log_a("t6 log", base);

    // 3: LFSR mode with zero seed
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    for (int i = 0; i < 3000 && done_b !== 1'b1; i++) @(negedge clock);
    check_eq("t3 done", done_b, 1'b1);
    check_eq("t3 count", wlog_b.size(), 64);
    if (wlog_b.size() >= 4) begin
      check_eq("t3 w0", wlog_b[0], 8'h01);
      check_eq("t3 w1", wlog_b[1], 8'hB8);
      check_eq("t3 w2", wlog_b[2], 8'h5C);
      check_eq("t3 w3", wlog_b[3], 8'h2E);
    end else begin
      check_eq("t3 first words", wlog_b.size(), 4);
    end
    lf = 8'h01; d = 0;
    for (int i = 0; i < wlog_b.size(); i++) begin
      if (wlog_b[i] !== lf) d++;
      lf = (lf >> 1) ^ (lf[0] ? 8'hB8 : 8'h00);
    end
    check_eq("t3 sequence", d, 0);
    check_eq("t3 error", err_b, 1'b0);
    check_eq("t3 ecnt", ecnt_b, 16'h0000);

    // 5: read latency 3, continuous bursts
    gaps = 0;
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    for (int i = 0; i < 3000 && done_c !== 1'b1; i++) begin
      if (busy_c && wlog_c.size() < 64 && !we_c) gaps++;
      @(negedge clock);
    end
    check_eq("t5 done", done_c, 1'b1);
    check_eq("t5 write gaps", gaps, 0);
    check_eq("t5 reads", pops_c, 64);
    check_eq("t5 count", wlog_c.size(), 64);
    check_eq("t5 error", err_c, 1'b0);
    check_eq("t5 ecnt", ecnt_c, 16'h0000);
    d = 0;
    for (int i = 0; i < wlog_c.size(); i++) begin
      if (wlog_c[i] !== 8'(i + 1)) d++;
    end
    check_eq("t5 words", d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
